// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared constants for the gate vector sequencer
// Contents: FSM state codes, vector count, gate output bit positions, Gray helper.
package gate_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int NUM_VEC = 4;

  localparam int BIT_AND  = 0;
  localparam int BIT_OR   = 1;
  localparam int BIT_NOT  = 2;
  localparam int BIT_NAND = 3;
  localparam int BIT_NOR  = 4;
  localparam int BIT_XOR  = 5;
  localparam int BIT_XNOR = 6;

  function automatic logic [1:0] gray_of(input logic [1:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational expected outputs of the 2-input gate block
// Ports:
//   vec      in  2  {a1,a2}
//   expected out 7  [0]=AND [1]=OR [2]=NOT a1 [3]=NAND [4]=NOR [5]=XOR [6]=XNOR
module gate_ref_model
  import gate_seq_pkg::*;
(
  input  logic [1:0] vec,
  output logic [6:0] expected
);

  logic a1;
  logic a2;

  assign a1 = vec[1];
  assign a2 = vec[0];

  always_comb begin
    expected           = '0;
    expected[BIT_AND]  = a1 & a2;
    expected[BIT_OR]   = a1 | a2;
    expected[BIT_NOT]  = ~a1;
    expected[BIT_NAND] = ~(a1 & a2);
    expected[BIT_NOR]  = ~(a1 | a2);
    expected[BIT_XOR]  = a1 ^ a2;
    expected[BIT_XNOR] = ~(a1 ^ a2);
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - sweeps a1/a2 through all vectors and checks the gate block outputs
// Optional macro GATE_SEQ_GRAY_EN: Gray sweep order 00,01,11,10 instead of binary.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            single-cycle run request, ignored while busy
//   a1, a2           registered gate inputs
//   y_in[6:0]        gate outputs under test
//   busy, done, pass run status; pass = done and no errors
//   err_cnt          saturating mismatch count
//   fail_vec         {a1,a2} of first failing sample
//   fail_mask        expected XOR y_in at first failing sample
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a1,
  output logic             a2,
  input  logic [6:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
);

  logic [1:0] state;
  logic [1:0] idx;
  logic [7:0] dwell;
  logic [7:0] sweep;
  logic       first_fail;

  logic [1:0] cur_vec;
  logic [6:0] exp_y;
  logic       mismatch;
  logic       sample;
  logic       last_vec;
  logic       last_sweep;

  function automatic logic [1:0] vec_of(input logic [1:0] i);
`ifdef GATE_SEQ_GRAY_EN
    return gray_of(i);
`else
    return i;
`endif
  endfunction

  assign cur_vec = {a1, a2};

  gate_ref_model u_ref (
    .vec      (cur_vec),
    .expected (exp_y)
  );

  assign mismatch   = (exp_y != y_in);
  assign sample     = (state == HOLD) && (dwell == 8'(SETTLE_CYCLES - 1));
  assign last_vec   = (idx == 2'(NUM_VEC - 1));
  assign last_sweep = (sweep == 8'(PASSES - 1));

  // pass is derived, so it can never disagree with done/err_cnt
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a1         <= 1'b0;
      a2         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_mask  <= '0;
      first_fail <= 1'b0;
      idx        <= '0;
      dwell      <= '0;
      sweep      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= HOLD;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
            first_fail <= 1'b0;
            idx        <= '0;
            {a1, a2}   <= vec_of(2'd0);
            dwell      <= '0;
            sweep      <= '0;
          end
        end
        HOLD: begin
          if (sample) begin
            if (mismatch) begin
              if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
              if (!first_fail) begin
                first_fail <= 1'b1;
                fail_vec   <= cur_vec;
                fail_mask  <= exp_y ^ y_in;
              end
            end
            dwell    <= '0;
            idx      <= idx + 2'd1;
            {a1, a2} <= vec_of(idx + 2'd1);
            if (last_vec) begin
              sweep <= sweep + 8'd1;
              if (last_sweep) begin
                // last sample of the run: park inputs at 00 and report
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                {a1, a2} <= 2'b00;
              end
            end
          end else begin
            dwell <= dwell + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - self-checking bench for gate_vector_sequencer
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0][6:0] and_m = '0;
  logic [2:0][6:0] or_m = '0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] ideal_y(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  logic a1_0, a2_0, busy_0, done_0, pass_0;
  logic a1_1, a2_1, busy_1, done_1, pass_1;
  logic a1_2, a2_2, busy_2, done_2, pass_2;
  logic [7:0] err_0, err_1;
  logic [1:0] err_2;
  logic [1:0] fv_0, fv_1, fv_2;
  logic [6:0] fm_0, fm_1, fm_2;
  logic [6:0] y_0, y_1, y_2;

  assign y_0 = (ideal_y({a1_0, a2_0}) & ~and_m[0]) | or_m[0];
  assign y_1 = (ideal_y({a1_1, a2_1}) & ~and_m[1]) | or_m[1];
  assign y_2 = (ideal_y({a1_2, a2_2}) & ~and_m[2]) | or_m[2];

  gate_vector_sequencer #(.SETTLE_CYCLES(4), .PASSES(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a1(a1_0), .a2(a2_0), .y_in(y_0),
    .busy(busy_0), .done(done_0), .pass(pass_0), .err_cnt(err_0),
    .fail_vec(fv_0), .fail_mask(fm_0));

  gate_vector_sequencer #(.SETTLE_CYCLES(4), .PASSES(2), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a1(a1_1), .a2(a2_1), .y_in(y_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .err_cnt(err_1),
    .fail_vec(fv_1), .fail_mask(fm_1));

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .PASSES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a1(a1_2), .a2(a2_2), .y_in(y_2),
    .busy(busy_2), .done(done_2), .pass(pass_2), .err_cnt(err_2),
    .fail_vec(fv_2), .fail_mask(fm_2));

  function automatic int settle_of(input int s);
    return (s == 2) ? 1 : 4;
  endfunction

  function automatic int passes_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 3);
  endfunction

  function automatic int cnt_max_of(input int s);
    return (s == 2) ? 3 : 255;
  endfunction

  // sweep order as the k-th vector visited within one sweep
  function automatic logic [1:0] order_of(input int k);
    logic [1:0] tbl [4];
`ifdef GATE_SEQ_GRAY_EN
    tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    tbl = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    return tbl[k % 4];
  endfunction

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] ab;
    logic [7:0] err;
    logic [1:0] fv;
    logic [6:0] fm;
  } obs_t;

  function automatic obs_t get_obs(input int s);
    obs_t o;
    case (s)
      0:       o = '{busy_0, done_0, pass_0, {a1_0, a2_0}, err_0, fv_0, fm_0};
      1:       o = '{busy_1, done_1, pass_1, {a1_1, a2_1}, err_1, fv_1, fm_1};
      default: o = '{busy_2, done_2, pass_2, {a1_2, a2_2}, {6'd0, err_2}, fv_2, fm_2};
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one complete run: every sample of every sweep
  task automatic model_run(input int s, input logic [6:0] am, input logic [6:0] om,
                           output logic [7:0] e_err, output logic [1:0] e_fv,
                           output logic [6:0] e_fm);
    int n;
    bit seen;
    logic [6:0] want, got;
    n = 0;
    seen = 0;
    e_fv = '0;
    e_fm = '0;
    for (int p = 0; p < passes_of(s); p++) begin
      for (int k = 0; k < 4; k++) begin
        want = ideal_y(order_of(k));
        got  = (want & ~am) | om;
        if (got != want) begin
          if (n < cnt_max_of(s)) n++;
          if (!seen) begin
            seen = 1;
            e_fv = order_of(k);
            e_fm = got ^ want;
          end
        end
      end
    end
    e_err = 8'(n);
  endtask

  task automatic run_one(input int s, input logic [6:0] am, input logic [6:0] om,
                         input logic [7:0] e_err, input logic [1:0] e_fv,
                         input logic [6:0] e_fm, input bit mid, input string tag);
    obs_t o;
    int st, total;
    st = settle_of(s);
    total = 4 * st * passes_of(s);
    @(negedge clk);
    and_m[s] = am;
    or_m[s]  = om;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    for (int t = 0; t < total; t++) begin
      o = get_obs(s);
      chk({tag, "_ab"}, 32'(o.ab), 32'(order_of(t / st)));
      chk({tag, "_busy"}, 32'(o.busy), 32'd1);
      chk({tag, "_done"}, 32'(o.done), 32'd0);
      if (mid && t == 2) start[s] = 1'b1;
      if (mid && t == 3) start[s] = 1'b0;
      @(negedge clk);
    end
    o = get_obs(s);
    chk({tag, "_end_done"}, 32'(o.done), 32'd1);
    chk({tag, "_end_busy"}, 32'(o.busy), 32'd0);
    chk({tag, "_end_ab"}, 32'(o.ab), 32'd0);
    chk({tag, "_err"}, 32'(o.err), 32'(e_err));
    chk({tag, "_pass"}, 32'(o.pass), 32'(e_err == 8'd0));
    chk({tag, "_fail_vec"}, 32'(o.fv), 32'(e_fv));
    chk({tag, "_fail_mask"}, 32'(o.fm), 32'(e_fm));
    // done must hold while idle
    repeat (3) @(negedge clk);
    o = get_obs(s);
    chk({tag, "_done_hold"}, 32'(o.done), 32'd1);
  endtask

  typedef struct {
    int         sel;
    logic [6:0] am;
    logic [6:0] om;
    logic [7:0] e_err;
    logic [1:0] e_fv;
    logic [6:0] e_fm;
    bit         mid;
    string      tag;
  } vec_t;

  vec_t tbl [4];
  obs_t o;

  initial begin
    logic [7:0] m_err;
    logic [1:0] m_fv;
    logic [6:0] m_fm;
    logic [6:0] am, om;
    int s;

    tbl[0] = '{0, 7'h00, 7'h00, 8'd0, 2'b00, 7'h00, 1'b0, "clean"};
    tbl[1] = '{1, 7'h20, 7'h00, 8'd4, 2'b01, 7'b0100000, 1'b0, "xor_stuck0"};
    tbl[2] = '{2, 7'h7f, 7'h00, 8'd3, 2'b00, 7'b1011100, 1'b0, "saturate"};
    tbl[3] = '{0, 7'h00, 7'h00, 8'd0, 2'b00, 7'h00, 1'b1, "mid_start"};

    // reset then idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i);
        chk("idle_outputs", 32'(o), 32'd0);
      end
    end

    for (int i = 0; i < 4; i++) begin
      run_one(tbl[i].sel, tbl[i].am, tbl[i].om, tbl[i].e_err, tbl[i].e_fv,
              tbl[i].e_fm, tbl[i].mid, tbl[i].tag);
    end

    // abort mid-run with errors already logged, then restart cleanly
    @(negedge clk);
    and_m[0] = 7'h00;
    or_m[0]  = 7'h7f;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    o = get_obs(0);
    chk("abort_pre_err", 32'(o.err != 0), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      chk("abort_outputs", 32'(o), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    or_m[0] = 7'h00;
    @(negedge clk);
    o = get_obs(0);
    chk("abort_still_zero", 32'(o), 32'd0);
    run_one(0, 7'h00, 7'h00, 8'd0, 2'b00, 7'h00, 1'b1, "restart");

    // randomized fault patterns against the behavioural model
    for (int r = 0; r < 10; r++) begin
      s  = $urandom_range(0, 2);
      am = 7'($urandom & $urandom);
      om = 7'($urandom & $urandom & $urandom);
      model_run(s, am, om, m_err, m_fv, m_fm);
      run_one(s, am, om, m_err, m_fv, m_fm, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
